// File: rtl/fast_square_pkg.sv
// Shared constants, readout types and helper functions for the fast square sweep receiver.
package fast_square_pkg;

    localparam logic [15:0] HDR_WORD = 16'h8000;
    localparam logic [15:0] SAT_POS  = 16'h7FFF;
    localparam logic [15:0] SAT_NEG  = 16'h8001;

    // Cordic datapath width: 16b input plus headroom for gain (~1.65) and sqrt(2) growth.
    localparam int unsigned CORDIC_XW = 20;
    // 1/K for ten micro-rotations, Q15.
    localparam logic signed [16:0] CORDIC_INV_GAIN = 17'sd19898;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RESTART,
        RD_HDR,
        RD_DATA
    } rd_state_e;

    // Readout word as presented on out_i/out_q/out_last.
    typedef struct packed {
        logic [15:0] data_i;
        logic [15:0] data_q;
        logic        last;
    } rx_word_t;

    // Harmonic index of channel k out of n: -n/2..-1, +1..+n/2 (zero skipped).
    function automatic int harmonic(input int k, input int n);
        return (k < n / 2) ? (k - n / 2) : (k - n / 2 + 1);
    endfunction

    // atan(2^-i) with a full turn mapped to 2^16.
    function automatic logic [15:0] cordic_atan(input int i);
        case (i)
            0:       return 16'd8192;
            1:       return 16'd4836;
            2:       return 16'd2555;
            3:       return 16'd1297;
            4:       return 16'd651;
            5:       return 16'd326;
            6:       return 16'd163;
            7:       return 16'd81;
            8:       return 16'd41;
            9:       return 16'd20;
            10:      return 16'd10;
            11:      return 16'd5;
            12:      return 16'd3;
            13:      return 16'd1;
            default: return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/fast_square_chan.sv
// One receive channel: harmonic subcarrier NCO, cordic mixer, integrator,
// shift/saturate and latched frame result.
// Ports: clk/rst_n; i_start (sweep restart), i_step (undelayed step, already masked by start),
// i_sub_set/i_sub_base (live/latched base increments), i_step_shift, i_carrier_hi (carrier
// phase msbs), i_bb_i/i_bb_q (baseband), i_record_d/i_step_d (delay-aligned controls),
// i_avg_log2, i_latch (store closed frame); o_res_i/o_res_q (latched frame result).
module fast_square_chan
    import fast_square_pkg::*;
#(
    parameter int unsigned NUM_SUBCARRIERS = 4,
    parameter int unsigned CHAN            = 0,
    parameter int unsigned ACC_WIDTH       = 36,
    parameter int unsigned CORDIC_DELAY    = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_step,
    input  logic [31:0] i_sub_set,
    input  logic [31:0] i_sub_base,
    input  logic [4:0]  i_step_shift,
    input  logic [15:0] i_carrier_hi,
    input  logic [15:0] i_bb_i,
    input  logic [15:0] i_bb_q,
    input  logic        i_record_d,
    input  logic        i_step_d,
    input  logic [4:0]  i_avg_log2,
    input  logic        i_latch,
    output logic [15:0] o_res_i,
    output logic [15:0] o_res_q
);

    localparam int unsigned ITERS = CORDIC_DELAY - 2;
    localparam int unsigned XW    = CORDIC_XW;
    localparam int unsigned PW    = XW + 17;
    localparam logic signed [31:0] H = 32'(harmonic(int'(CHAN), int'(NUM_SUBCARRIERS)));
    localparam logic signed [PW-1:0] P_MAX = PW'(32767);
    localparam logic signed [PW-1:0] P_MIN = PW'(-32768);
    localparam logic signed [ACC_WIDTH-1:0] A_MAX = ACC_WIDTH'(32767);
    localparam logic signed [ACC_WIDTH-1:0] A_MIN = ACC_WIDTH'(-32767);

    // Cordic output scaled back by 1/K and clipped to 16b.
    function automatic logic [15:0] sat_mix(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] s;
        s = p >>> 15;
        if (s > P_MAX) return 16'h7FFF;
        if (s < P_MIN) return 16'h8000;
        return s[15:0];
    endfunction

    // Scaled integrator value; 8000 stays reserved for header words.
    function automatic logic [15:0] sat_acc(input logic signed [ACC_WIDTH-1:0] v);
        if (v > A_MAX) return SAT_POS;
        if (v < A_MIN) return SAT_NEG;
        return v[15:0];
    endfunction

    logic [31:0] r_freq, r_phase;
    logic [31:0] w_start_freq, w_step_inc;
    logic [15:0] w_zi;
    logic        w_flip;
    logic signed [XW-1:0] w_xi, w_yi;
    logic signed [XW-1:0] r_x [ITERS+1];
    logic signed [XW-1:0] r_y [ITERS+1];
    logic [15:0]          r_z [ITERS];
    logic signed [PW-1:0] w_pi, w_pq;
    logic [15:0] r_bb_i, r_bb_q;
    logic signed [ACC_WIDTH-1:0] r_sum_i, r_sum_q;
    logic [15:0] r_res_i, r_res_q;

    assign w_start_freq = 32'(H * $signed(i_sub_set));
    assign w_step_inc   = 32'(H * $signed(i_sub_base << i_step_shift));

    // Subcarrier NCO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_freq  <= '0;
            r_phase <= '0;
        end else if (i_start) begin
            r_freq  <= w_start_freq;
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + r_freq;
            if (i_step) r_freq <= r_freq + w_step_inc;
        end
    end

    // Angles in the left half-plane are folded by negating the vector and adding pi.
    assign w_zi   = i_carrier_hi + r_phase[31:16];
    assign w_flip = w_zi[15] ^ w_zi[14];
    assign w_xi   = {{(XW-16){i_bb_i[15]}}, i_bb_i};
    assign w_yi   = {{(XW-16){i_bb_q[15]}}, i_bb_q};
    assign w_pi   = PW'(r_x[ITERS]) * PW'(CORDIC_INV_GAIN);
    assign w_pq   = PW'(r_y[ITERS]) * PW'(CORDIC_INV_GAIN);

    // Cordic rotation pipeline: fold stage, ITERS micro-rotations, gain stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= ITERS; s++) begin
                r_x[s] <= '0;
                r_y[s] <= '0;
            end
            for (int s = 0; s < ITERS; s++) r_z[s] <= '0;
            r_bb_i <= '0;
            r_bb_q <= '0;
        end else begin
            r_x[0] <= w_flip ? -w_xi : w_xi;
            r_y[0] <= w_flip ? -w_yi : w_yi;
            r_z[0] <= w_flip ? (w_zi ^ 16'h8000) : w_zi;
            for (int s = 0; s < ITERS; s++) begin
                if (!r_z[s][15]) begin
                    r_x[s+1] <= r_x[s] - (r_y[s] >>> s);
                    r_y[s+1] <= r_y[s] + (r_x[s] >>> s);
                    if (s + 1 < ITERS) r_z[s+1] <= r_z[s] - cordic_atan(s);
                end else begin
                    r_x[s+1] <= r_x[s] + (r_y[s] >>> s);
                    r_y[s+1] <= r_y[s] - (r_x[s] >>> s);
                    if (s + 1 < ITERS) r_z[s+1] <= r_z[s] + cordic_atan(s);
                end
            end
            r_bb_i <= sat_mix(w_pi);
            r_bb_q <= sat_mix(w_pq);
        end
    end

    // Integrator; the sample coinciding with a step is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_i <= '0;
            r_sum_q <= '0;
        end else if (i_start || i_step_d) begin
            r_sum_i <= '0;
            r_sum_q <= '0;
        end else if (i_record_d) begin
            r_sum_i <= r_sum_i + {{(ACC_WIDTH-16){r_bb_i[15]}}, r_bb_i};
            r_sum_q <= r_sum_q + {{(ACC_WIDTH-16){r_bb_q[15]}}, r_bb_q};
        end
    end

    // Frame result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_i <= '0;
            r_res_q <= '0;
        end else if (i_latch) begin
            r_res_i <= sat_acc(r_sum_i >>> i_avg_log2);
            r_res_q <= sat_acc(r_sum_q >>> i_avg_log2);
        end
    end

    assign o_res_i = r_res_i;
    assign o_res_q = r_res_q;

endmodule

// File: rtl/fast_square_sweep_rx.sv
// Multi-subcarrier sweep receiver: settings registers, carrier NCO, control delay line,
// per-channel integrators and a framed valid/ready readout.
// Ports: clock/reset_n; sweep_start, freq_step, record; serial_addr/data/strobe settings bus;
// i_in/q_in baseband; out_valid/out_ready/out_i/out_q/out_last readout; overrun sticky flag.
module fast_square_sweep_rx
    import fast_square_pkg::*;
#(
    parameter int unsigned CARRIERFREQADDR    = 0,
    parameter int unsigned SUBCARRIERFREQADDR = 0,
    parameter int unsigned CTRLADDR           = 0,
    parameter int unsigned NUM_SUBCARRIERS    = 4,
    parameter int unsigned ACC_WIDTH          = 36,
    parameter int unsigned CORDIC_DELAY       = 12
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sweep_start,
    input  logic        freq_step,
    input  logic        record,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        serial_strobe,
    input  logic [15:0] i_in,
    input  logic [15:0] q_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_i,
    output logic [15:0] out_q,
    output logic        out_last,
    output logic        overrun
);

    localparam int unsigned N    = NUM_SUBCARRIERS;
    localparam int unsigned CH_W = $clog2(N);
    localparam int unsigned D    = CORDIC_DELAY;

    logic [31:0] r_carrier_set, r_sub_set, r_sub_base;
    logic [4:0]  r_avg_log2, r_step_shift;
    logic [31:0] r_carrier_freq, r_carrier_phase;
    logic [D-1:0] r_rec_dly, r_step_dly;
    logic        w_step_live, w_close, w_latch, w_acc, w_last_acc;
    logic        r_pending, r_overrun;
    logic [15:0] r_frame_seq;
    logic [15:0] w_res_i [N];
    logic [15:0] w_res_q [N];
    rd_state_e   r_state, w_nxt_state;
    rx_word_t    r_word, w_nxt_word;
    logic        r_valid, w_nxt_valid;
    logic [CH_W-1:0] r_ch, w_nxt_ch, w_ch_inc;

    // Settings bus; frequencies only reach the NCOs at sweep_start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_carrier_set <= '0;
            r_sub_set     <= '0;
            r_avg_log2    <= '0;
            r_step_shift  <= '0;
        end else if (serial_strobe) begin
            if (serial_addr == 7'(CARRIERFREQADDR))    r_carrier_set <= serial_data;
            if (serial_addr == 7'(SUBCARRIERFREQADDR)) r_sub_set     <= serial_data;
            if (serial_addr == 7'(CTRLADDR)) begin
                r_avg_log2   <= serial_data[4:0];
                r_step_shift <= serial_data[9:5];
            end
        end
    end

    // Carrier NCO and the latched subcarrier base used by steps.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_carrier_freq  <= '0;
            r_carrier_phase <= '0;
            r_sub_base      <= '0;
        end else if (sweep_start) begin
            r_carrier_freq  <= r_carrier_set;
            r_carrier_phase <= '0;
            r_sub_base      <= r_sub_set;
        end else begin
            r_carrier_phase <= r_carrier_phase + r_carrier_freq;
        end
    end

    // Align record/step with the cordic output.
    assign w_step_live = freq_step & ~sweep_start;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rec_dly  <= '0;
            r_step_dly <= '0;
        end else begin
            r_rec_dly  <= {r_rec_dly[D-2:0], record};
            r_step_dly <= {r_step_dly[D-2:0], w_step_live};
        end
    end

    assign w_close = r_step_dly[D-1] & ~sweep_start;
    assign w_latch = w_close & ~r_pending;

    for (genvar k = 0; k < N; k++) begin : g_chan
        fast_square_chan #(
            .NUM_SUBCARRIERS(N),
            .CHAN           (k),
            .ACC_WIDTH      (ACC_WIDTH),
            .CORDIC_DELAY   (CORDIC_DELAY)
        ) u_chan (
            .clk         (clock),
            .rst_n       (reset_n),
            .i_start     (sweep_start),
            .i_step      (w_step_live),
            .i_sub_set   (r_sub_set),
            .i_sub_base  (r_sub_base),
            .i_step_shift(r_step_shift),
            .i_carrier_hi(r_carrier_phase[31:16]),
            .i_bb_i      (i_in),
            .i_bb_q      (q_in),
            .i_record_d  (r_rec_dly[D-1]),
            .i_step_d    (r_step_dly[D-1]),
            .i_avg_log2  (r_avg_log2),
            .i_latch     (w_latch),
            .o_res_i     (w_res_i[k]),
            .o_res_q     (w_res_q[k])
        );
    end

    // Frame bookkeeping: one frame may wait for readout, later closes are dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pending   <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_seq <= '0;
        end else if (sweep_start) begin
            r_pending   <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_seq <= '0;
        end else begin
            if (w_latch) begin
                r_pending   <= 1'b1;
                r_frame_seq <= r_frame_seq + 16'd1;
            end else if (w_close) begin
                r_overrun <= 1'b1;
            end
            if (w_last_acc) r_pending <= 1'b0;
        end
    end

    // Readout state register and registered output word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RD_IDLE;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_ch    <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_word  <= w_nxt_word;
            r_valid <= w_nxt_valid;
            r_ch    <= w_nxt_ch;
        end
    end

    assign w_acc    = r_valid & out_ready;
    assign w_ch_inc = r_ch + CH_W'(1);

    // Readout next-state; a sweep_start preempts anything in flight with RESTART.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_word  = r_word;
        w_nxt_valid = r_valid;
        w_nxt_ch    = r_ch;
        w_last_acc  = 1'b0;
        if (sweep_start) begin
            w_nxt_state = RD_RESTART;
            w_nxt_valid = 1'b1;
            w_nxt_word  = '{data_i: HDR_WORD, data_q: 16'h0000, last: 1'b1};
        end else begin
            case (r_state)
                RD_IDLE: begin
                    if (r_pending) begin
                        w_nxt_state = RD_HDR;
                        w_nxt_valid = 1'b1;
                        w_nxt_word  = '{data_i: HDR_WORD, data_q: r_frame_seq, last: 1'b0};
                    end
                end
                RD_RESTART: begin
                    if (w_acc) begin
                        w_nxt_state = RD_IDLE;
                        w_nxt_valid = 1'b0;
                    end
                end
                RD_HDR: begin
                    if (w_acc) begin
                        w_nxt_state = RD_DATA;
                        w_nxt_ch    = '0;
                        w_nxt_word  = '{data_i: w_res_i[0], data_q: w_res_q[0], last: 1'b0};
                    end
                end
                RD_DATA: begin
                    if (w_acc) begin
                        if (r_ch == CH_W'(N - 1)) begin
                            w_nxt_state = RD_IDLE;
                            w_nxt_valid = 1'b0;
                            w_last_acc  = 1'b1;
                        end else begin
                            w_nxt_ch   = w_ch_inc;
                            w_nxt_word = '{data_i: w_res_i[w_ch_inc], data_q: w_res_q[w_ch_inc],
                                           last: (w_ch_inc == CH_W'(N - 1))};
                        end
                    end
                end
                default: begin
                    w_nxt_state = RD_IDLE;
                    w_nxt_valid = 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign out_i     = r_word.data_i;
    assign out_q     = r_word.data_q;
    assign out_last  = r_word.last;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_fast_square_sweep_rx.sv
module tb_fast_square_sweep_rx;

    localparam int D = 12;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        sweep_start, freq_step, record;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;
    logic [15:0] i_in, q_in;
    logic        out_valid, out_ready, out_last, overrun;
    logic [15:0] out_i, out_q;

    int n_checks = 0;
    int n_errors = 0;

    fast_square_sweep_rx #(
        .CARRIERFREQADDR   (1),
        .SUBCARRIERFREQADDR(2),
        .CTRLADDR          (3),
        .NUM_SUBCARRIERS   (4),
        .ACC_WIDTH         (36),
        .CORDIC_DELAY      (D)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sweep_start  (sweep_start),
        .freq_step    (freq_step),
        .record       (record),
        .serial_addr  (serial_addr),
        .serial_data  (serial_data),
        .serial_strobe(serial_strobe),
        .i_in         (i_in),
        .q_in         (q_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_i        (out_i),
        .out_q        (out_q),
        .out_last     (out_last),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [15:0] obs, input logic [15:0] exp,
                              input int tol);
        int d;
        if (tol == 0) begin
            check(tag, 32'(obs), 32'(exp));
        end else begin
            d = int'($signed(obs)) - int'($signed(exp));
            check($sformatf("%s(got %h want %h+-%0d)", tag, obs, exp, tol),
                  32'((d <= tol) && (d >= -tol)), 32'd1);
        end
    endtask

    task automatic write_reg(input logic [6:0] a, input logic [31:0] d);
        @(negedge clock);
        serial_addr = a; serial_data = d; serial_strobe = 1'b1;
        @(negedge clock);
        serial_strobe = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        sweep_start = 1'b1;
        @(negedge clock);
        sweep_start = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] ii, input int n);
        @(negedge clock);
        i_in = ii; record = 1'b1;
        repeat (n) @(negedge clock);
        record = 1'b0; freq_step = 1'b1;
        @(negedge clock);
        freq_step = 1'b0;
    endtask

    // Wait for a word, hold it for 'stall' cycles checking it each cycle, then accept it.
    // tol < 0 skips the q field.
    task automatic expect_word(input string tag, input logic [15:0] ei, input logic [15:0] eq,
                               input int tol_i, input int tol_q, input logic el, input int stall);
        bit got = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (out_valid) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            check({tag, "_timeout"}, 32'(out_valid), 32'd1);
            return;
        end
        out_ready = (stall == 0);
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) @(negedge clock);
            check($sformatf("%s_valid_s%0d", tag, s), 32'(out_valid), 32'd1);
            check_near($sformatf("%s_i_s%0d", tag, s), out_i, ei, tol_i);
            if (tol_q >= 0) check_near($sformatf("%s_q_s%0d", tag, s), out_q, eq, tol_q);
            check($sformatf("%s_last_s%0d", tag, s), 32'(out_last), 32'(el));
            if (s == stall) out_ready = 1'b1;
        end
    endtask

    initial begin
        reset_n = 1'b0; sweep_start = 0; freq_step = 0; record = 0;
        serial_addr = '0; serial_data = '0; serial_strobe = 0;
        i_in = '0; q_in = '0; out_ready = 0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_i", 32'(out_i), 0);
        check("rst_q", 32'(out_q), 0);
        check("rst_last", 32'(out_last), 0);
        check("rst_overrun", 32'(overrun), 0);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        check("post_rst_quiet", 32'(out_valid), 0);

        // RESTART word on sweep_start
        write_reg(7'd1, 32'd0);
        write_reg(7'd2, 32'd0);
        write_reg(7'd3, 32'd4);
        out_ready = 1'b0;
        pulse_start();
        expect_word("t2_restart", 16'h8000, 16'h0000, 0, 0, 1'b1, 0);
        repeat (10) @(negedge clock);
        check("t2_single_word", 32'(out_valid), 0);

        // 0x1000 over 64 samples >> 4 -> 0x4000 per channel
        run_frame(16'h1000, 64);
        expect_word("t3_hdr", 16'h8000, 16'h0001, 0, 0, 1'b0, 0);
        for (int k = 0; k < 4; k++)
            expect_word($sformatf("t3_d%0d", k), 16'h4000, 16'h0000, 64, 64, 1'b0 | (k == 3), 0);

        // Positive and negative saturation
        write_reg(7'd3, 32'd0);
        run_frame(16'h7FFF, 1024);
        expect_word("t4p_hdr", 16'h8000, 16'h0002, 0, 0, 1'b0, 0);
        for (int k = 0; k < 4; k++)
            expect_word($sformatf("t4p_d%0d", k), 16'h7FFF, 16'h0000, 0, -1, 1'b0 | (k == 3), 0);
        run_frame(16'h8000, 1024);
        expect_word("t4n_hdr", 16'h8000, 16'h0003, 0, 0, 1'b0, 0);
        for (int k = 0; k < 4; k++)
            expect_word($sformatf("t4n_d%0d", k), 16'h8001, 16'h0000, 0, -1, 1'b0 | (k == 3), 0);

        // Back-pressure: second frame dropped, overrun set, first frame intact
        write_reg(7'd3, 32'd4);
        out_ready = 1'b0;
        run_frame(16'h1000, 64);
        run_frame(16'h0800, 64);
        repeat (D + 3) @(negedge clock);
        check("t5_overrun", 32'(overrun), 1);
        expect_word("t5_hdr", 16'h8000, 16'h0004, 0, 0, 1'b0, 3);
        for (int k = 0; k < 4; k++)
            expect_word($sformatf("t5_d%0d", k), 16'h4000, 16'h0000, 64, 64, 1'b0 | (k == 3), 0);
        repeat (20) @(negedge clock);
        check("t5_dropped", 32'(out_valid), 0);

        // Abort during DATA word 2 with stalls on every word
        run_frame(16'h1000, 64);
        expect_word("t6_hdr", 16'h8000, 16'h0005, 0, 0, 1'b0, 2);
        expect_word("t6_d0", 16'h4000, 16'h0000, 64, 64, 1'b0, 2);
        expect_word("t6_d1", 16'h4000, 16'h0000, 64, 64, 1'b0, 2);
        @(negedge clock);
        out_ready = 1'b0;
        check("t6_d2_valid", 32'(out_valid), 1);
        check("t6_d2_last", 32'(out_last), 0);
        sweep_start = 1'b1;
        @(negedge clock);
        sweep_start = 1'b0;
        check("t6_overrun_clr", 32'(overrun), 0);
        expect_word("t6_restart", 16'h8000, 16'h0000, 0, 0, 1'b1, 1);
        repeat (10) @(negedge clock);
        check("t6_quiet", 32'(out_valid), 0);

        // Asynchronous reset while a frame is held and overrun is set
        out_ready = 1'b0;
        run_frame(16'h1000, 8);
        run_frame(16'h1000, 8);
        repeat (D + 3) @(negedge clock);
        check("t7_pre_overrun", 32'(overrun), 1);
        check("t7_pre_valid", 32'(out_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        check("t7_async_valid", 32'(out_valid), 0);
        check("t7_async_overrun", 32'(overrun), 0);
        check("t7_async_i", 32'(out_i), 0);
        @(negedge clock);
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (20) @(negedge clock);
        check("t7_post_quiet", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
